// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter.
// The ST_ABORT state exists only when WB_ARB_TIMEOUT_EN is defined.
package wb_arb_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  // Owner encodings, shared by o_grant and the last_owner register
  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
`ifdef WB_ARB_TIMEOUT_EN
    ,
    ST_ABORT = 2'd3
`endif
  } arb_state_t;

  // Maps an FSM state to the owner it grants; ABORT and IDLE grant nobody
  function automatic logic [1:0] owner_of(arb_state_t s);
    case (s)
      ST_GNT_A: return OWNER_A;
      ST_GNT_B: return OWNER_B;
      default:  return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Slave-silence watchdog: counts consecutive cycles in which the owner holds
// cyc without receiving ack or err, and flags when TIMEOUT_CYCLES is reached.
module wb_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_run,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] count;

  assign o_expired = (count == CNT_W'(TIMEOUT_CYCLES));

  // Count silent cycles; any response or loss of the grant restarts from zero,
  // and the count holds at the limit until the arbiter leaves the grant
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (!i_run) begin
      count <= '0;
    end else if (!o_expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter. A grant is held until the owner
// drops cyc, and an IDLE cycle always separates two owners. Define
// WB_ARB_TIMEOUT_EN to abort a grant whose slave stays silent for
// TIMEOUT_CYCLES cycles (err to the owner, then ABORT until it drops cyc).
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  // master A
  input  logic              i_a_wb_cyc,
  input  logic              i_a_wb_stb,
  input  logic              i_a_wb_we,
  input  logic [ADDR_W-1:0] i_a_wb_addr,
  input  logic [DATA_W-1:0] i_a_wb_data,
  input  logic [SEL_W-1:0]  i_a_wb_sel,
  output logic              o_a_wb_stall,
  output logic              o_a_wb_ack,
  output logic              o_a_wb_err,
  output logic [DATA_W-1:0] o_a_wb_data,
  // master B
  input  logic              i_b_wb_cyc,
  input  logic              i_b_wb_stb,
  input  logic              i_b_wb_we,
  input  logic [ADDR_W-1:0] i_b_wb_addr,
  input  logic [DATA_W-1:0] i_b_wb_data,
  input  logic [SEL_W-1:0]  i_b_wb_sel,
  output logic              o_b_wb_stall,
  output logic              o_b_wb_ack,
  output logic              o_b_wb_err,
  output logic [DATA_W-1:0] o_b_wb_data,
  // slave
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [SEL_W-1:0]  o_wb_sel,
  input  logic              i_wb_stall,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [1:0]        o_grant
);

  arb_state_t state, state_nxt;
  logic [1:0] last_owner;
  logic [1:0] grant_q;
  logic       owner_cyc;
  logic       timeout_hit;

  assign owner_cyc = ((state == ST_GNT_A) && i_a_wb_cyc) ||
                     ((state == ST_GNT_B) && i_b_wb_cyc);
  assign o_grant   = grant_q;

`ifdef WB_ARB_TIMEOUT_EN
  logic to_run;
  logic to_expired;

  assign to_run      = owner_cyc && !i_wb_ack && !i_wb_err;
  assign timeout_hit = to_expired && owner_cyc;

  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_run     (to_run),
    .o_expired (to_expired)
  );
`else
  // The parameter stays on the interface so both builds share one port map
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  // Next-state selection: round-robin in IDLE, hold while the owner keeps cyc
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_a_wb_cyc && i_b_wb_cyc) begin
          state_nxt = (last_owner == OWNER_A) ? ST_GNT_B : ST_GNT_A;
        end else if (i_a_wb_cyc) begin
          state_nxt = ST_GNT_A;
        end else if (i_b_wb_cyc) begin
          state_nxt = ST_GNT_B;
        end
      end
      ST_GNT_A: begin
        if (!i_a_wb_cyc) begin
          state_nxt = ST_IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_nxt = ST_ABORT;
`endif
        end
      end
      ST_GNT_B: begin
        if (!i_b_wb_cyc) begin
          state_nxt = ST_IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_nxt = ST_ABORT;
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_ABORT: begin
        // Wait for the aborted owner to let go before arbitrating again
        if (!((last_owner == OWNER_A) ? i_a_wb_cyc : i_b_wb_cyc)) begin
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, registered grant and round-robin history
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: reset leaves last_owner at B so that A wins the first contest
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      grant_q    <= OWNER_NONE;
      last_owner <= OWNER_B;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values
      state   <= state_nxt;
      grant_q <= owner_of(state_nxt);
      if (state_nxt != state) begin
        if (state == ST_GNT_A) last_owner <= OWNER_A;
        if (state == ST_GNT_B) last_owner <= OWNER_B;
      end
    end
  end

  // Bus routing: the owner is wired straight to the slave; everyone else is
  // stalled and sees no responses, so stray acks/errs are dropped
  always_comb begin
    o_wb_cyc     = 1'b0;
    o_wb_stb     = 1'b0;
    o_wb_we      = 1'b0;
    o_wb_addr    = '0;
    o_wb_data    = '0;
    o_wb_sel     = '0;
    o_a_wb_stall = 1'b1;
    o_a_wb_ack   = 1'b0;
    o_a_wb_err   = 1'b0;
    o_a_wb_data  = '0;
    o_b_wb_stall = 1'b1;
    o_b_wb_ack   = 1'b0;
    o_b_wb_err   = 1'b0;
    o_b_wb_data  = '0;
    if (timeout_hit) begin
      // Slave side is cut off this cycle; the owner only gets the err pulse
      o_a_wb_err = (state == ST_GNT_A);
      o_b_wb_err = (state == ST_GNT_B);
    end else if (state == ST_GNT_A) begin
      o_wb_cyc     = i_a_wb_cyc;
      o_wb_stb     = i_a_wb_stb;
      o_wb_we      = i_a_wb_we;
      o_wb_addr    = i_a_wb_addr;
      o_wb_data    = i_a_wb_data;
      o_wb_sel     = i_a_wb_sel;
      o_a_wb_stall = i_wb_stall;
      o_a_wb_ack   = i_wb_ack;
      o_a_wb_err   = i_wb_err;
      o_a_wb_data  = i_wb_data;
    end else if (state == ST_GNT_B) begin
      o_wb_cyc     = i_b_wb_cyc;
      o_wb_stb     = i_b_wb_stb;
      o_wb_we      = i_b_wb_we;
      o_wb_addr    = i_b_wb_addr;
      o_wb_data    = i_b_wb_data;
      o_wb_sel     = i_b_wb_sel;
      o_b_wb_stall = i_wb_stall;
      o_b_wb_ack   = i_wb_ack;
      o_b_wb_err   = i_wb_err;
      o_b_wb_data  = i_wb_data;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter. Responses expected by the stimulus
// are queued; a negedge monitor pops and compares each master response.
// With WB_ARB_TIMEOUT_EN defined the slave-silence abort path is exercised,
// otherwise grant persistence under a silent slave is checked.
module tb_wb_rr_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_a_wb_cyc, i_a_wb_stb, i_a_wb_we;
  logic [29:0] i_a_wb_addr;
  logic [31:0] i_a_wb_data;
  logic [3:0]  i_a_wb_sel;
  logic        o_a_wb_stall, o_a_wb_ack, o_a_wb_err;
  logic [31:0] o_a_wb_data;
  logic        i_b_wb_cyc, i_b_wb_stb, i_b_wb_we;
  logic [29:0] i_b_wb_addr;
  logic [31:0] i_b_wb_data;
  logic [3:0]  i_b_wb_sel;
  logic        o_b_wb_stall, o_b_wb_ack, o_b_wb_err;
  logic [31:0] o_b_wb_data;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [29:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall, i_wb_ack, i_wb_err;
  logic [31:0] i_wb_data;
  logic [1:0]  o_grant;

  typedef struct {
    logic [1:0]  who;
    logic        is_err;
    logic [31:0] data;
  } resp_t;

  resp_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  wb_rr_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_a_wb_cyc   (i_a_wb_cyc),
    .i_a_wb_stb   (i_a_wb_stb),
    .i_a_wb_we    (i_a_wb_we),
    .i_a_wb_addr  (i_a_wb_addr),
    .i_a_wb_data  (i_a_wb_data),
    .i_a_wb_sel   (i_a_wb_sel),
    .o_a_wb_stall (o_a_wb_stall),
    .o_a_wb_ack   (o_a_wb_ack),
    .o_a_wb_err   (o_a_wb_err),
    .o_a_wb_data  (o_a_wb_data),
    .i_b_wb_cyc   (i_b_wb_cyc),
    .i_b_wb_stb   (i_b_wb_stb),
    .i_b_wb_we    (i_b_wb_we),
    .i_b_wb_addr  (i_b_wb_addr),
    .i_b_wb_data  (i_b_wb_data),
    .i_b_wb_sel   (i_b_wb_sel),
    .o_b_wb_stall (o_b_wb_stall),
    .o_b_wb_ack   (o_b_wb_ack),
    .o_b_wb_err   (o_b_wb_err),
    .o_b_wb_data  (o_b_wb_data),
    .o_wb_cyc     (o_wb_cyc),
    .o_wb_stb     (o_wb_stb),
    .o_wb_we      (o_wb_we),
    .o_wb_addr    (o_wb_addr),
    .o_wb_data    (o_wb_data),
    .o_wb_sel     (o_wb_sel),
    .i_wb_stall   (i_wb_stall),
    .i_wb_ack     (i_wb_ack),
    .i_wb_err     (i_wb_err),
    .i_wb_data    (i_wb_data),
    .o_grant      (o_grant)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive point just after the rising edge; sample point on the falling edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_clk);
  endtask

  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [29:0] addr, input logic [31:0] data);
    if (m == 0) begin
      i_a_wb_cyc = cyc; i_a_wb_stb = stb; i_a_wb_we = we;
      i_a_wb_addr = addr; i_a_wb_data = data; i_a_wb_sel = 4'hF;
    end else begin
      i_b_wb_cyc = cyc; i_b_wb_stb = stb; i_b_wb_we = we;
      i_b_wb_addr = addr; i_b_wb_data = data; i_b_wb_sel = 4'hF;
    end
  endtask

  // Bounded wait for any grant, then compare against the expected owner
  task automatic wait_grant(input string tag, input logic [1:0] want);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      mid();
      if (o_grant != 2'b00) got = 1'b1;
      else tick();
    end
    check(tag, 32'(o_grant), 32'(want));
    tick();
  endtask

  // One single transfer by the current owner m; the slave acks next cycle
  task automatic do_xfer(input int m, input logic we, input logic [29:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata);
    drive(m, 1'b1, 1'b1, we, addr, wdata);
    mid();
    check("xfer_grant", 32'(o_grant), (m == 0) ? 32'h1 : 32'h2);
    check("xfer_stb", 32'(o_wb_stb), 32'h1);
    check("xfer_addr", 32'(o_wb_addr), 32'(addr));
    check("xfer_we", 32'(o_wb_we), 32'(we));
    check("xfer_wdata", o_wb_data, wdata);
    check("xfer_other_stall", 32'((m == 0) ? o_b_wb_stall : o_a_wb_stall), 32'h1);
    tick();
    drive(m, 1'b1, 1'b0, we, addr, wdata);
    i_wb_ack  = 1'b1;
    i_wb_data = rdata;
    exp_q.push_back('{(m == 0) ? 2'b01 : 2'b10, 1'b0, rdata});
    mid();
    tick();
    i_wb_ack  = 1'b0;
    i_wb_data = 32'h0;
  endtask

  // Response monitor: every ack/err seen by a master must match the queue head
  always @(negedge i_clk) begin : mon
    logic [1:0]  who;
    logic        err;
    logic [31:0] data, other;
    resp_t       e;
    who = {o_b_wb_ack | o_b_wb_err, o_a_wb_ack | o_a_wb_err};
    if (who != 2'b00) begin
      err   = who[0] ? o_a_wb_err  : o_b_wb_err;
      data  = who[0] ? o_a_wb_data : o_b_wb_data;
      other = who[0] ? o_b_wb_data : o_a_wb_data;
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'(who), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("resp_who", 32'(who), 32'(e.who));
        check("resp_err", 32'(err), 32'(e.is_err));
        check("resp_data", data, e.data);
        check("resp_other_data", other, 32'h0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    i_reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = 32'h0;

    // Reset state
    mid();
    check("rst_grant", 32'(o_grant), 32'h0);
    check("rst_a_stall", 32'(o_a_wb_stall), 32'h1);
    check("rst_b_stall", 32'(o_b_wb_stall), 32'h1);
    check("rst_wb_cyc", 32'(o_wb_cyc), 32'h0);
    check("rst_acks", 32'({o_a_wb_ack, o_b_wb_ack, o_a_wb_err, o_b_wb_err}), 32'h0);
    tick();
    i_reset_n = 1'b1;
    tick();

    // A alone: arbitration cycle stalls, then write passes through
    drive(0, 1'b1, 1'b1, 1'b1, 30'h100, 32'hDEADBEEF);
    mid();
    check("arb_grant", 32'(o_grant), 32'h0);
    check("arb_a_stall", 32'(o_a_wb_stall), 32'h1);
    check("arb_wb_cyc", 32'(o_wb_cyc), 32'h0);
    tick();
    mid();
    check("a_grant", 32'(o_grant), 32'h1);
    check("a_wb_cyc", 32'(o_wb_cyc), 32'h1);
    check("a_wb_sel", 32'(o_wb_sel), 32'hF);
    tick();
    do_xfer(0, 1'b1, 30'h100, 32'hDEADBEEF, 32'h0);
    drive(0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    mid();
    check("a_rel_hold", 32'(o_grant), 32'h1);
    tick();
    mid();
    check("a_rel_idle", 32'(o_grant), 32'h0);
    tick();

    // Both request right after reset: A, then one IDLE cycle, then B
    i_reset_n = 1'b0;
    #1;
    check("rst2_grant", 32'(o_grant), 32'h0);
    tick();
    i_reset_n = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
    wait_grant("both_first", 2'b01);
    do_xfer(0, 1'b1, 30'h200, 32'h11111111, 32'h0);
    drive(0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    mid();
    check("hand_hold_a", 32'(o_grant), 32'h1);
    tick();
    mid();
    check("hand_idle", 32'(o_grant), 32'h0);
    tick();
    mid();
    check("hand_b", 32'(o_grant), 32'h2);
    tick();
    do_xfer(1, 1'b1, 30'h300, 32'h22222222, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    tick();
    tick();

    // Alternation: both keep requesting, grants go A,B,A,B
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      wait_grant("alt_grant", (i % 2 == 0) ? 2'b01 : 2'b10);
      do_xfer(i % 2, 1'b1, 30'(32'h400 + i), 32'hA0A0_0000 + 32'(i), 32'h0000_0F00 + 32'(i));
      drive(i % 2, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
      tick();
      drive(i % 2, 1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    tick();
    tick();

    // B read: slave data reaches B only
    drive(1, 1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
    wait_grant("b_read_grant", 2'b10);
    do_xfer(1, 1'b0, 30'h2A, 32'h0, 32'h12345678);
    drive(1, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    tick();
    tick();

    // Owner drops cyc with a strobe outstanding; the late ack is dropped
    drive(0, 1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
    wait_grant("late_grant", 2'b01);
    drive(0, 1'b1, 1'b1, 1'b0, 30'h50, 32'h0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    tick();
    i_wb_ack = 1'b1;
    mid();
    check("late_grant_idle", 32'(o_grant), 32'h0);
    check("late_ack_a", 32'(o_a_wb_ack), 32'h0);
    check("late_ack_b", 32'(o_b_wb_ack), 32'h0);
    tick();
    i_wb_ack = 1'b0;

    // Reset during a B transfer; a following ack reaches nobody
    drive(1, 1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
    wait_grant("rstx_grant", 2'b10);
    drive(1, 1'b1, 1'b1, 1'b0, 30'h60, 32'h0);
    tick();
    i_reset_n = 1'b0;
    #1;
    check("rstx_grant_now", 32'(o_grant), 32'h0);
    check("rstx_wb_cyc", 32'(o_wb_cyc), 32'h0);
    check("rstx_b_stall", 32'(o_b_wb_stall), 32'h1);
    i_wb_ack = 1'b1;
    mid();
    check("rstx_ack_a", 32'(o_a_wb_ack), 32'h0);
    check("rstx_ack_b", 32'(o_b_wb_ack), 32'h0);
    tick();
    i_wb_ack = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    i_reset_n = 1'b1;
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Silent slave: err to A after 8 silent granted cycles, then ABORT
    begin
      int first_k;
      first_k = -1;
      drive(0, 1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
      wait_grant("to_grant", 2'b01);
      drive(0, 1'b1, 1'b1, 1'b0, 30'h70, 32'h0);
      exp_q.push_back('{2'b01, 1'b1, 32'h0});
      for (int k = 1; k <= 14; k++) begin
        mid();
        if (o_a_wb_err && first_k < 0) begin
          first_k = k;
          check("to_cyc_drop", 32'(o_wb_cyc), 32'h0);
        end
        tick();
      end
      check("to_latency", 32'(first_k), 32'd8);
      mid();
      check("abort_grant", 32'(o_grant), 32'h0);
      check("abort_wb_cyc", 32'(o_wb_cyc), 32'h0);
      tick();
      drive(0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
      tick();
      drive(1, 1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
      wait_grant("after_abort", 2'b10);
      drive(1, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
      tick();
      tick();
    end
`else
    // Silent slave without the watchdog: the grant simply persists
    begin
      logic saw_err;
      logic lost;
      saw_err = 1'b0;
      lost    = 1'b0;
      drive(0, 1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
      wait_grant("hold_grant", 2'b01);
      drive(0, 1'b1, 1'b1, 1'b0, 30'h70, 32'h0);
      for (int k = 0; k < 20; k++) begin
        mid();
        if (o_a_wb_err) saw_err = 1'b1;
        if (o_grant != 2'b01) lost = 1'b1;
        tick();
      end
      check("hold_no_err", 32'(saw_err), 32'h0);
      check("hold_no_loss", 32'(lost), 32'h0);
      check("hold_wb_cyc", 32'(o_wb_cyc), 32'h1);
      drive(0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
      tick();
      tick();
    end
`endif

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
